// File: rtl/rnn_mem_responder_pkg.sv
// rnn_mem_responder_pkg: bank encodings, depths and address-range helper shared by the responder slice
package rnn_mem_responder_pkg;
  localparam int DW = 20;
  localparam int OUT_DEPTH = 2048;
  localparam int WIH_DEPTH = 2048;
  localparam int WHH_DEPTH = 4096;
  localparam int BIAS_DEPTH = 64;
  localparam logic [11:0] CNT_MAX = 12'hFFF;
  localparam logic [2:0] SEL_WIH = 3'b000;
  localparam logic [2:0] SEL_BIH = 3'b001;
  localparam logic [2:0] SEL_WHH = 3'b010;
  localparam logic [2:0] SEL_BHH = 3'b011;
  localparam logic [2:0] SEL_CFG = 3'b100;
  localparam logic [2:0] SEL_OUT = 3'b101;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DUMP} state_t;
  function automatic logic addr_ok(input logic [2:0] sel, input logic [16:0] a);
    return sel == SEL_WIH ? ~|a[16:11] :
           sel == SEL_BIH || sel == SEL_BHH ? ~|a[16:6] :
           sel == SEL_WHH ? ~|a[16:12] :
           sel == SEL_CFG ? ~|a :
           sel == SEL_OUT ? ~|a[16:11] : 1'b0;
  endfunction
endpackage

// File: rtl/rnn_mem_responder_if.sv
// rnn_mem_responder_if: core memory port plus host preload/readback port
interface rnn_mem_responder_if;
  import rnn_mem_responder_pkg::*;
  logic mce;
  logic [2:0] msel;
  logic [16:0] maddr;
  logic [DW-1:0] mdata_w;
  logic [DW-1:0] mdata_r;
  logic ld_valid;
  logic ld_ready;
  logic [2:0] ld_sel;
  logic [16:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic rd_req;
  logic [10:0] rd_addr;
  logic rd_valid;
  logic [DW-1:0] rd_data;
  logic [11:0] out_cnt;
  logic err;
  modport slave (
    input mce, msel, maddr, mdata_w, ld_valid, ld_sel, ld_addr, ld_data, rd_req, rd_addr,
    output mdata_r, ld_ready, rd_valid, rd_data, out_cnt, err
  );
  modport master (
    output mce, msel, maddr, mdata_w, ld_valid, ld_sel, ld_addr, ld_data, rd_req, rd_addr,
    input mdata_r, ld_ready, rd_valid, rd_data, out_cnt, err
  );
endinterface

// File: rtl/rnn_mem_responder_bank.sv
// rnn_bank_ram: single-write-port storage bank with asynchronous read
module rnn_bank_ram
  import rnn_mem_responder_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int W = DW,
  parameter int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic we,
  input logic [AW-1:0] waddr,
  input logic [W-1:0] wdata,
  input logic [AW-1:0] raddr,
  output logic [W-1:0] rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/rnn_mem_responder.sv
// rnn_mem_responder: six-bank memory between host loader and RNN core; decode, arbitration and host FSM
module rnn_mem_responder
  import rnn_mem_responder_pkg::*;
(
  input logic clk,
  input logic reset,
  rnn_mem_responder_if.slave m
);
  state_t state, nxt;
  logic host_wr, core_wr;
  logic [DW-1:0] wih_q, bih_q, whh_q, bhh_q, out_q, t_reg;
  // ld_ready is low whenever mce is high, so core and host writes never coincide
  assign host_wr = m.ld_valid && m.ld_ready && addr_ok(m.ld_sel, m.ld_addr);
  assign core_wr = m.mce && m.msel == SEL_OUT && addr_ok(m.msel, m.maddr);
  rnn_bank_ram #(.DEPTH(WIH_DEPTH)) u_wih (.clk, .we(host_wr && m.ld_sel == SEL_WIH),
    .waddr(m.ld_addr[10:0]), .wdata(m.ld_data), .raddr(m.maddr[10:0]), .rdata(wih_q));
  rnn_bank_ram #(.DEPTH(BIAS_DEPTH)) u_bih (.clk, .we(host_wr && m.ld_sel == SEL_BIH),
    .waddr(m.ld_addr[5:0]), .wdata(m.ld_data), .raddr(m.maddr[5:0]), .rdata(bih_q));
  rnn_bank_ram #(.DEPTH(WHH_DEPTH)) u_whh (.clk, .we(host_wr && m.ld_sel == SEL_WHH),
    .waddr(m.ld_addr[11:0]), .wdata(m.ld_data), .raddr(m.maddr[11:0]), .rdata(whh_q));
  rnn_bank_ram #(.DEPTH(BIAS_DEPTH)) u_bhh (.clk, .we(host_wr && m.ld_sel == SEL_BHH),
    .waddr(m.ld_addr[5:0]), .wdata(m.ld_data), .raddr(m.maddr[5:0]), .rdata(bhh_q));
  rnn_bank_ram #(.DEPTH(OUT_DEPTH)) u_out (.clk, .we(core_wr || (host_wr && m.ld_sel == SEL_OUT)),
    .waddr(core_wr ? m.maddr[10:0] : m.ld_addr[10:0]), .wdata(core_wr ? m.mdata_w : m.ld_data),
    .raddr(m.mce ? m.maddr[10:0] : m.rd_addr), .rdata(out_q));
  always_ff @(posedge clk) state <= reset ? IDLE : nxt;
  always_comb begin
    nxt = m.mce ? RUN : m.ld_valid ? LOAD : m.rd_req ? DUMP : IDLE;
    m.ld_ready = state == LOAD && !m.mce;
    m.mdata_r = (reset || !m.mce || !addr_ok(m.msel, m.maddr)) ? '0 :
                m.msel == SEL_WIH ? wih_q :
                m.msel == SEL_BIH ? bih_q :
                m.msel == SEL_WHH ? whh_q :
                m.msel == SEL_BHH ? bhh_q :
                m.msel == SEL_CFG ? t_reg : out_q;
  end
  always_ff @(posedge clk) if (host_wr && m.ld_sel == SEL_CFG) t_reg <= m.ld_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      m.rd_valid <= 1'b0;
      m.rd_data <= '0;
      m.out_cnt <= '0;
      m.err <= 1'b0;
    end else begin
      m.rd_valid <= m.rd_req && !m.mce;
      if (m.rd_req && !m.mce) m.rd_data <= out_q;
      if (host_wr && m.ld_sel == SEL_OUT && ~|m.ld_addr) m.out_cnt <= '0;
      else if (core_wr && m.out_cnt != CNT_MAX) m.out_cnt <= m.out_cnt + 12'd1;
      m.err <= m.err | (m.mce && !addr_ok(m.msel, m.maddr))
                     | (m.ld_valid && m.ld_ready && !addr_ok(m.ld_sel, m.ld_addr));
    end
  end
endmodule

// File: tb/tb_rnn_mem_responder.sv
// tb_rnn_mem_responder: directed checks of preload, core access, readback, contention and error paths
module tb_rnn_mem_responder;
  import rnn_mem_responder_pkg::*;
  logic clk = 0;
  logic reset = 1;
  int tests = 0;
  int fails = 0;
  rnn_mem_responder_if bus();
  rnn_mem_responder dut (.clk(clk), .reset(reset), .m(bus));
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic host_write(input logic [2:0] sel, input logic [16:0] addr, input logic [DW-1:0] data);
    int n = 0;
    bus.ld_valid = 1; bus.ld_sel = sel; bus.ld_addr = addr; bus.ld_data = data;
    #1;
    while (!bus.ld_ready && n < 8) begin step(); n++; end
    if (n == 8) begin
      tests++; fails++;
      $display("FAIL host_write_timeout: ld_ready got 0 expected 1");
    end
    step();
    bus.ld_valid = 0;
  endtask

  task automatic core_read(input logic [2:0] sel, input logic [16:0] addr);
    bus.mce = 1; bus.msel = sel; bus.maddr = addr;
    step();
  endtask

  task automatic readback(input logic [10:0] addr);
    bus.rd_req = 1; bus.rd_addr = addr;
    step();
    bus.rd_req = 0;
  endtask

  task automatic do_reset();
    bus.mce = 0; bus.ld_valid = 0; bus.rd_req = 0;
    reset = 1;
    step(); step();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    if (bus.mdata_r !== 20'h0) begin tests++; fails++; $display("FAIL rst_mdata_r: got %h expected 0", bus.mdata_r); end else tests++;
    if (bus.ld_ready !== 1'b0) begin tests++; fails++; $display("FAIL rst_ld_ready: got %b expected 0", bus.ld_ready); end else tests++;
    if (bus.rd_valid !== 1'b0) begin tests++; fails++; $display("FAIL rst_rd_valid: got %b expected 0", bus.rd_valid); end else tests++;
    if (bus.rd_data !== 20'h0) begin tests++; fails++; $display("FAIL rst_rd_data: got %h expected 0", bus.rd_data); end else tests++;
    if (bus.out_cnt !== 12'h0) begin tests++; fails++; $display("FAIL rst_out_cnt: got %h expected 0", bus.out_cnt); end else tests++;
    if (bus.err !== 1'b0) begin tests++; fails++; $display("FAIL rst_err: got %b expected 0", bus.err); end else tests++;
  endtask

  task automatic test_preload();
    host_write(SEL_WIH, 17'd5, 20'h10000);
    host_write(SEL_BHH, 17'd3, 20'h0FFFF);
    core_read(SEL_WIH, 17'd5);
    if (bus.mdata_r !== 20'h10000) begin tests++; fails++; $display("FAIL wih5: got %h expected 10000", bus.mdata_r); end else tests++;
    core_read(SEL_BHH, 17'd3);
    if (bus.mdata_r !== 20'h0FFFF) begin tests++; fails++; $display("FAIL bhh3: got %h expected 0ffff", bus.mdata_r); end else tests++;
    bus.mce = 0; #1;
    if (bus.mdata_r !== 20'h0) begin tests++; fails++; $display("FAIL mdata_r_idle: got %h expected 0", bus.mdata_r); end else tests++;
    if (bus.err !== 1'b0) begin tests++; fails++; $display("FAIL preload_err: got %b expected 0", bus.err); end else tests++;
  endtask

  task automatic test_cfg();
    host_write(SEL_CFG, 17'd0, 20'd3);
    core_read(SEL_CFG, 17'd0);
    if (bus.mdata_r !== 20'd3) begin tests++; fails++; $display("FAIL cfg_t: got %h expected 3", bus.mdata_r); end else tests++;
    bus.mce = 0;
  endtask

  task automatic test_core_writes();
    bus.mce = 1; bus.msel = SEL_OUT;
    for (int i = 0; i < 64; i++) begin
      bus.maddr = 17'(i); bus.mdata_w = 20'(i);
      step();
    end
    bus.mce = 0;
    if (bus.out_cnt !== 12'd64) begin tests++; fails++; $display("FAIL out_cnt64: got %0d expected 64", bus.out_cnt); end else tests++;
    readback(11'd63);
    if (bus.rd_valid !== 1'b1) begin tests++; fails++; $display("FAIL rd_valid63: got %b expected 1", bus.rd_valid); end else tests++;
    if (bus.rd_data !== 20'd63) begin tests++; fails++; $display("FAIL rd_data63: got %h expected 3f", bus.rd_data); end else tests++;
    bus.rd_req = 1; bus.rd_addr = 11'd10;
    step();
    if (bus.rd_data !== 20'd10 || bus.rd_valid !== 1'b1) begin tests++; fails++; $display("FAIL b2b_rd10: got %h expected a", bus.rd_data); end else tests++;
    bus.rd_addr = 11'd20;
    step();
    if (bus.rd_data !== 20'd20 || bus.rd_valid !== 1'b1) begin tests++; fails++; $display("FAIL b2b_rd20: got %h expected 14", bus.rd_data); end else tests++;
    bus.rd_req = 0;
    step();
    if (bus.rd_valid !== 1'b0) begin tests++; fails++; $display("FAIL rd_valid_drop: got %b expected 0", bus.rd_valid); end else tests++;
    bus.mce = 1; bus.msel = SEL_WIH; bus.maddr = 17'd0; bus.rd_req = 1; bus.rd_addr = 11'd5;
    step();
    if (bus.rd_valid !== 1'b0) begin tests++; fails++; $display("FAIL rd_during_mce: got %b expected 0", bus.rd_valid); end else tests++;
    bus.rd_req = 0; bus.mce = 0;
    step();
  endtask

  task automatic test_contention();
    logic stuck = 0;
    bus.mce = 1; bus.msel = SEL_WIH; bus.maddr = 17'd0;
    bus.ld_valid = 1; bus.ld_sel = SEL_BIH; bus.ld_addr = 17'd7; bus.ld_data = 20'h12345;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.ld_ready !== 1'b0) stuck = 1;
    end
    if (stuck) begin tests++; fails++; $display("FAIL ld_ready_during_mce: got 1 expected 0"); end else tests++;
    bus.mce = 0; #1;
    if (bus.ld_ready !== 1'b0) begin tests++; fails++; $display("FAIL ld_ready_mce_fall: got %b expected 0", bus.ld_ready); end else tests++;
    step();
    if (bus.ld_ready !== 1'b1) begin tests++; fails++; $display("FAIL ld_ready_after: got %b expected 1", bus.ld_ready); end else tests++;
    step();
    bus.ld_valid = 0;
    core_read(SEL_BIH, 17'd7);
    if (bus.mdata_r !== 20'h12345) begin tests++; fails++; $display("FAIL bih7: got %h expected 12345", bus.mdata_r); end else tests++;
    bus.mce = 0;
  endtask

  task automatic test_illegal();
    core_read(3'b110, 17'd0);
    if (bus.mdata_r !== 20'h0) begin tests++; fails++; $display("FAIL illegal_mdata_r: got %h expected 0", bus.mdata_r); end else tests++;
    bus.mce = 0;
    step(); step();
    if (bus.err !== 1'b1) begin tests++; fails++; $display("FAIL err_sticky: got %b expected 1", bus.err); end else tests++;
    do_reset();
    if (bus.err !== 1'b0) begin tests++; fails++; $display("FAIL err_cleared: got %b expected 0", bus.err); end else tests++;
    core_read(SEL_BIH, 17'd64);
    if (bus.mdata_r !== 20'h0) begin tests++; fails++; $display("FAIL oor_mdata_r: got %h expected 0", bus.mdata_r); end else tests++;
    bus.mce = 0;
    step();
    if (bus.err !== 1'b1) begin tests++; fails++; $display("FAIL oor_err: got %b expected 1", bus.err); end else tests++;
    do_reset();
  endtask

  task automatic test_saturation();
    bus.mce = 1; bus.msel = SEL_OUT; bus.mdata_w = 20'h0;
    for (int i = 0; i < 4100; i++) begin
      bus.maddr = 17'(i % 2048);
      step();
    end
    bus.mce = 0;
    if (bus.out_cnt !== 12'd4095) begin tests++; fails++; $display("FAIL out_cnt_sat: got %0d expected 4095", bus.out_cnt); end else tests++;
    host_write(SEL_OUT, 17'd0, 20'h00777);
    if (bus.out_cnt !== 12'd0) begin tests++; fails++; $display("FAIL out_cnt_clear: got %0d expected 0", bus.out_cnt); end else tests++;
    readback(11'd0);
    if (bus.rd_data !== 20'h00777) begin tests++; fails++; $display("FAIL host_out0: got %h expected 777", bus.rd_data); end else tests++;
  endtask

  task automatic test_reset_mid_run();
    logic bad = 0;
    bus.mce = 1; bus.msel = SEL_OUT;
    for (int i = 0; i < 5; i++) begin
      bus.maddr = 17'(i); bus.mdata_w = 20'(100 + i);
      step();
    end
    if (bus.out_cnt !== 12'd5) begin tests++; fails++; $display("FAIL out_cnt5: got %0d expected 5", bus.out_cnt); end else tests++;
    bus.maddr = 17'd5; bus.mdata_w = 20'd105; reset = 1;
    step();
    reset = 0; bus.mce = 0;
    if (bus.out_cnt !== 12'd0) begin tests++; fails++; $display("FAIL mid_run_out_cnt: got %0d expected 0", bus.out_cnt); end else tests++;
    if (bus.err !== 1'b0) begin tests++; fails++; $display("FAIL mid_run_err: got %b expected 0", bus.err); end else tests++;
    for (int i = 0; i < 5; i++) begin
      readback(11'(i));
      if (bus.rd_data !== 20'(100 + i)) begin
        bad = 1;
        $display("FAIL retained_out%0d: got %0d expected %0d", i, bus.rd_data, 100 + i);
      end
    end
    tests++;
    if (bad) fails++;
  endtask

  initial begin
    bus.mce = 0; bus.msel = 0; bus.maddr = 0; bus.mdata_w = 0;
    bus.ld_valid = 0; bus.ld_sel = 0; bus.ld_addr = 0; bus.ld_data = 0;
    bus.rd_req = 0; bus.rd_addr = 0;
    test_reset();
    test_preload();
    test_cfg();
    test_core_writes();
    test_contention();
    test_illegal();
    test_saturation();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
